dbns_job_scheduler: RTL and testbench

- Arbitrates two requesters for one shared 16-bit DBNS conversion path: binary-to-DBNS converter followed by the DBNS-to-binary de-converter.
- Round-robin grant between requesters.
- Sequences both stages with start/done handshakes, watchdogs each stage, and returns the result tagged with the requester ID.
- Sits between the multiplier front end and the shared converter instances.

---
 rtl/dbns_job_scheduler.sv | 122 ++++++++++++
 tb/tb_dbns_job_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dbns_job_scheduler.sv
// Round-robin job scheduler for the shared 16-bit DBNS converter / de-converter pair.
// Sequences both stages with start/done handshakes and a per-stage watchdog.
module dbns_job_scheduler #(
   parameter int TIMEOUT = 64,
   parameter int TW      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [15:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [15:0] req1_data,
   output logic        req1_ready,
   output logic        conv_start,
   output logic [15:0] conv_data,
   input  logic        conv_done,
   output logic        deconv_start,
   input  logic        deconv_done,
   input  logic [15:0] deconv_result,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        rsp_id,
   output logic        rsp_err,
   input  logic        rsp_ready,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, CONV, DECONV, RESP} state_t;

   localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

   state_t        state;
   logic          last_grant;
   logic          job_id;
   logic [TW-1:0] watchdog;
   logic          grant;
   logic          accept;

   // On contention the requester that did not win last time is served.
   always_comb begin
      grant  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
      accept = (state == IDLE) & (req0_valid | req1_valid);
   end

   assign req0_ready = accept & ~grant;
   assign req1_ready = accept & grant;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         conv_start   <= 1'b0;
         deconv_start <= 1'b0;
         conv_data    <= '0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         rsp_id       <= 1'b0;
         rsp_err      <= 1'b0;
         last_grant   <= 1'b1;
         job_id       <= 1'b0;
         watchdog     <= '0;
      end else begin
         // NOTE: start strobes default low here so every set lasts exactly one cycle.
         conv_start   <= 1'b0;
         deconv_start <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  conv_data  <= grant ? req1_data : req0_data;
                  job_id     <= grant;
                  last_grant <= grant;
                  conv_start <= 1'b1;
                  watchdog   <= '0;
                  state      <= CONV;
               end
            end
            CONV: begin
               // A done seen alongside the start pulse belongs to no job; it is masked.
               if (conv_done && !conv_start) begin
                  deconv_start <= 1'b1;
                  watchdog     <= '0;
                  state        <= DECONV;
               end else if (watchdog == WD_LAST) begin
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_id    <= job_id;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  watchdog <= watchdog + 1'b1;
               end
            end
            DECONV: begin
               if (deconv_done && !deconv_start) begin
                  rsp_data  <= deconv_result;
                  rsp_err   <= 1'b0;
                  rsp_id    <= job_id;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if (watchdog == WD_LAST) begin
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_id    <= job_id;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  watchdog <= watchdog + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dbns_job_scheduler.sv
// Directed bench for dbns_job_scheduler: converter stubs fire done in the Nth cycle
// of a stage (the start-pulse cycle is cycle 1); outputs are sampled on the falling edge.
module tb_dbns_job_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic [15:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic        conv_start, deconv_start;
   logic [15:0] conv_data;
   logic        conv_done, deconv_done;
   logic [15:0] deconv_result;
   logic        rsp_valid, rsp_id, rsp_err, rsp_ready, busy;
   logic [15:0] rsp_data;

   int errors = 0;
   int checks = 0;

   // converter stub controls
   logic c_en = 1'b1, d_en = 1'b1;
   int   c_n = 3, d_n = 2;
   int   cc = 0, dd = 0;
   logic stray_conv = 1'b0, stray_deconv = 1'b0;

   dbns_job_scheduler #(.TIMEOUT(64), .TW(8)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .conv_start(conv_start), .conv_data(conv_data), .conv_done(conv_done),
      .deconv_start(deconv_start), .deconv_done(deconv_done), .deconv_result(deconv_result),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
      .rsp_ready(rsp_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cc <= conv_start   ? 1 : ((cc != 0 && cc != c_n) ? cc + 1 : 0);
      dd <= deconv_start ? 1 : ((dd != 0 && dd != d_n) ? dd + 1 : 0);
   end

   assign conv_done     = (c_en && cc != 0 && cc == c_n) | stray_conv;
   assign deconv_done   = (d_en && dd != 0 && dd == d_n) | stray_deconv;
   assign deconv_result = conv_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_rsp(input string tag, input int max, output int lat);
      lat = 0;
      while (!rsp_valid && lat < max) begin
         tick();
         lat++;
      end
      check({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   lat;
      int   n;
      logic seen;

      rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
      req0_data = '0; req1_data = '0; rsp_ready = 1'b0;
      tick(); tick();
      check("rst_strobes", {30'd0, conv_start, deconv_start}, 32'd0);
      check("rst_conv_data", 32'(conv_data), 32'd0);
      check("rst_rsp", {13'd0, rsp_valid, rsp_data, rsp_id, rsp_err}, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;

      // 1: single job, conv done in cycle 3, deconv done in cycle 2
      req0_valid = 1'b1; req0_data = 16'h0011;
      #1;
      check("t1_ready", {30'd0, req1_ready, req0_ready}, 32'b01);
      tick();
      req0_valid = 1'b0;
      check("t1_conv_start", 32'(conv_start), 32'd1);
      check("t1_conv_data", 32'(conv_data), 32'h0011);
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("t1_latency", 32'(lat), 32'd6);
      check("t1_rsp", {14'd0, rsp_data, rsp_id, rsp_err}, {14'd0, 16'h0011, 1'b0, 1'b0});
      rsp_ready = 1'b1;
      tick();
      check("t1_after_hs", {30'd0, rsp_valid, busy}, 32'd0);

      // 2: contention from reset, grants alternate starting with requester 0
      rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = 16'h0005; req1_data = 16'h0009; c_n = 2; d_n = 2;
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!(req0_ready | req1_ready) && n < 20) begin
            tick();
            n++;
         end
         check("t2_grant", {30'd0, req1_ready, req0_ready}, (i % 2 == 1) ? 32'b10 : 32'b01);
         tick();
         wait_rsp("t2", 20, lat);
         check("t2_rsp_id", 32'(rsp_id), 32'(i % 2));
         check("t2_rsp_data", 32'(rsp_data), (i % 2 == 1) ? 32'h0009 : 32'h0005);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();

      // 3: back-pressure in RESP with requester 1 waiting
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_data = 16'h1234;
      tick();
      req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 16'h0077;
      wait_rsp("t3", 20, lat);
      for (int i = 0; i < 10; i++) begin
         check("t3_hold", {11'd0, rsp_valid, rsp_data, rsp_id, rsp_err, req1_ready, busy},
               {11'd0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1});
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      check("t3_hs_ready1", 32'(req1_ready), 32'd0);
      tick();
      check("t3_next_ready1", {30'd0, req1_ready, rsp_valid}, 32'b10);
      tick();
      req1_valid = 1'b0;
      check("t3_conv_data", 32'(conv_data), 32'h0077);
      wait_rsp("t3b", 20, lat);
      check("t3_rsp", {14'd0, rsp_data, rsp_id, rsp_err}, {14'd0, 16'h0077, 1'b1, 1'b0});
      tick();

      // 4: converter never finishes
      c_en = 1'b0;
      req0_valid = 1'b1; req0_data = 16'h00AB;
      tick();
      req0_valid = 1'b0;
      seen = 1'b0; lat = 0;
      while (!rsp_valid && lat < 100) begin
         tick();
         lat++;
         seen = seen | deconv_start;
      end
      check("t4_latency", 32'(lat), 32'd64);
      check("t4_rsp", {14'd0, rsp_data, rsp_id, rsp_err}, {14'd0, 16'h0000, 1'b0, 1'b1});
      check("t4_no_deconv_start", 32'(seen), 32'd0);
      c_en = 1'b1;
      tick();

      // 5: deconv done on the watchdog's final cycle, then stray dones while idle
      c_n = 2; d_n = 64;
      req0_valid = 1'b1; req0_data = 16'h0C0D;
      tick();
      req0_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 100) begin
         tick();
         lat++;
      end
      check("t5_latency", 32'(lat), 32'd66);
      check("t5_rsp", {14'd0, rsp_data, rsp_id, rsp_err}, {14'd0, 16'h0C0D, 1'b0, 1'b0});
      tick();
      stray_conv = 1'b1; stray_deconv = 1'b1;
      tick();
      stray_conv = 1'b0; stray_deconv = 1'b0;
      tick();
      check("t5_stray", {28'd0, busy, conv_start, deconv_start, rsp_valid}, 32'd0);

      // 6: reset in DECONV; the late done must not produce a response
      c_n = 2; d_n = 6;
      req0_valid = 1'b1; req0_data = 16'h00EE;
      tick();
      req0_valid = 1'b0;
      n = 0;
      while (!deconv_start && n < 10) begin
         tick();
         n++;
      end
      check("t6_deconv_start_at", 32'(n), 32'd2);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_rst_flags", {26'd0, busy, conv_start, deconv_start, rsp_valid, rsp_id, rsp_err}, 32'd0);
      check("t6_rst_data", {conv_data, rsp_data}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         seen = seen | rsp_valid | busy;
      end
      check("t6_late_done_ignored", 32'(seen), 32'd0);
      d_n = 2;
      req0_valid = 1'b1; req0_data = 16'h0042;
      #1;
      check("t6_new_ready0", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      wait_rsp("t6", 20, lat);
      check("t6_rsp", {14'd0, rsp_data, rsp_id, rsp_err}, {14'd0, 16'h0042, 1'b0, 1'b0});
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
